// File: rtl/pulse_meter.sv
// pulse_meter: synchronises a periodic pulse line and measures its
// period and high width in clk cycles; flags loss of pulses.
// Ports:
//   clk, rst_n        system clock, async active-low reset
//   p_in              pulse input (may be asynchronous to clk)
//   period, width     last measured period / high width (CNT_W bits)
//   meas_valid        1-cycle strobe when period/width update
//   rise_tick         1-cycle strobe per synchronised rising edge
//   timeout           sticky: no rising edge for TIMEOUT cycles
//   locked            high while measuring
// Optional (macro PULSE_METER_MINMAX_EN):
//   minmax_clr        sync clear of the min/max trackers
//   min_period        smallest period seen since reset/clear
//   max_period        largest period seen since reset/clear
module pulse_meter #(
    parameter int CNT_W       = 33,
    parameter int TIMEOUT     = 50000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             p_in,
`ifdef PULSE_METER_MINMAX_EN
    input  logic             minmax_clr,
    output logic [CNT_W-1:0] min_period,
    output logic [CNT_W-1:0] max_period,
`endif
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] width,
    output logic             meas_valid,
    output logic             rise_tick,
    output logic             timeout,
    output logic             locked
);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_pd;
    logic                   r_rise;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_pcnt;
    logic [CNT_W-1:0]       r_wcnt;
    logic [CNT_W-1:0]       r_period;
    logic [CNT_W-1:0]       r_width;
    logic                   r_valid;
    logic                   r_timeout;

    logic                   w_ps;
    logic                   w_rise;
    logic [CNT_W-1:0]       w_pinc;
    logic [CNT_W-1:0]       w_winc;
    state_t                 w_state_n;
    logic [CNT_W-1:0]       w_pcnt_n;
    logic [CNT_W-1:0]       w_wcnt_n;
    logic [CNT_W-1:0]       w_period_n;
    logic [CNT_W-1:0]       w_width_n;
    logic                   w_valid_n;
    logic                   w_timeout_n;

    assign w_ps   = r_sync[SYNC_STAGES-1];
    assign w_rise = w_ps & ~r_pd;

    // Saturating increments: counters stick at all-ones, never wrap.
    assign w_pinc = (&r_pcnt) ? r_pcnt : r_pcnt + ONE;
    assign w_winc = (w_ps && !(&r_wcnt)) ? r_wcnt + ONE : r_wcnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_pd   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], p_in};
            r_pd   <= w_ps;
            r_rise <= w_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pcnt    <= '0;
            r_wcnt    <= '0;
            r_period  <= '0;
            r_width   <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_pcnt    <= w_pcnt_n;
            r_wcnt    <= w_wcnt_n;
            r_period  <= w_period_n;
            r_width   <= w_width_n;
            r_valid   <= w_valid_n;
            r_timeout <= w_timeout_n;
        end
    end

    // A rise takes priority over the timeout check in the same cycle.
    always_comb begin
        w_state_n   = r_state;
        w_pcnt_n    = r_pcnt;
        w_wcnt_n    = r_wcnt;
        w_period_n  = r_period;
        w_width_n   = r_width;
        w_valid_n   = 1'b0;
        w_timeout_n = r_timeout;
        unique case (r_state)
            S_IDLE: begin
                w_pcnt_n = '0;
                w_wcnt_n = '0;
                if (w_rise) begin
                    w_state_n   = S_MEASURE;
                    w_pcnt_n    = ONE;
                    w_wcnt_n    = ONE;
                    w_timeout_n = 1'b0;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_period_n = r_pcnt;
                    w_width_n  = r_wcnt;
                    w_valid_n  = 1'b1;
                    w_pcnt_n   = ONE;
                    w_wcnt_n   = ONE;
                end else if (r_pcnt == TO_LAST) begin
                    w_timeout_n = 1'b1;
                    w_state_n   = S_IDLE;
                    w_pcnt_n    = '0;
                    w_wcnt_n    = '0;
                end else begin
                    w_pcnt_n = w_pinc;
                    w_wcnt_n = w_winc;
                end
            end
        endcase
    end

    assign period     = r_period;
    assign width      = r_width;
    assign meas_valid = r_valid;
    assign rise_tick  = r_rise;
    assign timeout    = r_timeout;
    assign locked     = (r_state == S_MEASURE);

`ifdef PULSE_METER_MINMAX_EN
    logic [CNT_W-1:0] r_min;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] w_min_base;
    logic [CNT_W-1:0] w_max_base;
    logic [CNT_W-1:0] w_min_n;
    logic [CNT_W-1:0] w_max_n;

    // Clear first, then fold in a sample arriving the same cycle.
    always_comb begin
        w_min_base = minmax_clr ? '1 : r_min;
        w_max_base = minmax_clr ? '0 : r_max;
        w_min_n    = w_min_base;
        w_max_n    = w_max_base;
        if (w_valid_n) begin
            if (r_pcnt < w_min_base) w_min_n = r_pcnt;
            if (r_pcnt > w_max_base) w_max_n = r_pcnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_min <= '1;
            r_max <= '0;
        end else begin
            r_min <= w_min_n;
            r_max <= w_max_n;
        end
    end

    assign min_period = r_min;
    assign max_period = r_max;
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// tb_pulse_meter: directed and randomised pulse trains checked against
// a pulse-level model of expected period/width/min/max results.
module tb_pulse_meter;

    localparam int     CW   = 16;
    localparam int     TO   = 20;
    localparam int     SS   = 2;
    localparam longint ALL1 = (longint'(1) << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          p_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] width;
    logic          meas_valid;
    logic          rise_tick;
    logic          timeout;
    logic          locked;
`ifdef PULSE_METER_MINMAX_EN
    logic          minmax_clr = 1'b0;
    logic [CW-1:0] min_period;
    logic [CW-1:0] max_period;
`endif

    pulse_meter #(
        .CNT_W      (CW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p_in      (p_in),
`ifdef PULSE_METER_MINMAX_EN
        .minmax_clr(minmax_clr),
        .min_period(min_period),
        .max_period(max_period),
`endif
        .period    (period),
        .width     (width),
        .meas_valid(meas_valid),
        .rise_tick (rise_tick),
        .timeout   (timeout),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint p;
        longint w;
        longint mn;
        longint mx;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_meas = 0;
    int     n_exp = 0;
    bit     m_armed = 1'b0;
    longint m_prev_p = 0;
    longint m_prev_w = 0;
    longint m_min = ALL1;
    longint m_max = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: each rise closes the previous pulse; it yields a result
    // only if that pulse ended before the timeout.
    task automatic bookkeep(input int P, input int W, input bit clr);
        if (clr) begin
            m_min = ALL1;
            m_max = 0;
        end
        if (m_armed && m_prev_p < longint'(TO)) begin
            if (m_prev_p < m_min) m_min = m_prev_p;
            if (m_prev_p > m_max) m_max = m_prev_p;
            exp_q.push_back('{m_prev_p, m_prev_w, m_min, m_max});
            n_exp++;
        end
        m_armed  = 1'b1;
        m_prev_p = longint'(P);
        m_prev_w = longint'(W);
    endtask

    // One pulse: high W cycles, low P-W cycles. With clr, minmax_clr is
    // raised in the cycle the rise of this pulse reaches the meter.
    task automatic pulse(input int P, input int W, input bit clr);
        bookkeep(P, W, clr);
        for (int i = 0; i < P; i++) begin
            p_in = (i < W);
`ifdef PULSE_METER_MINMAX_EN
            minmax_clr = clr && (i == SS);
`endif
            @(posedge clk);
            #1;
        end
`ifdef PULSE_METER_MINMAX_EN
        minmax_clr = 1'b0;
`endif
    endtask

    task automatic do_reset();
        p_in  = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_period", 64'(period), 64'(0));
        check("rst_width", 64'(width), 64'(0));
        check("rst_meas_valid", 64'(meas_valid), 64'(0));
        check("rst_rise_tick", 64'(rise_tick), 64'(0));
        check("rst_timeout", 64'(timeout), 64'(0));
        check("rst_locked", 64'(locked), 64'(0));
        check("rst_no_pending", 64'(exp_q.size()), 64'(0));
`ifdef PULSE_METER_MINMAX_EN
        check("rst_min", 64'(min_period), 64'(ALL1));
        check("rst_max", 64'(max_period), 64'(0));
`endif
        exp_q.delete();
        m_armed = 1'b0;
        m_min   = ALL1;
        m_max   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n && meas_valid) begin
            n_meas++;
            check("meas_with_rise_tick", 64'(rise_tick), 64'(1));
            check("meas_expected", 64'(exp_q.size() > 0), 64'(1));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("period", 64'(period), 64'(e.p));
                check("width", 64'(width), 64'(e.w));
`ifdef PULSE_METER_MINMAX_EN
                check("min_period", 64'(min_period), 64'(e.mn));
                check("max_period", 64'(max_period), 64'(e.mx));
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int n;
        #3;
        do_reset();

        // Steady 10/4 train: results from the second rise on.
        repeat (6) pulse(10, 4, 1'b0);
        check("t1_meas_count", 64'(n_meas), 64'(n_exp));
        check("t1_meas_count_abs", 64'(n_meas), 64'(5));
        check("t1_timeout", 64'(timeout), 64'(0));
        check("t1_locked", 64'(locked), 64'(1));

        // Single rise, then held low until timeout.
        do_reset();
        p_in = 1'b1;
        @(posedge clk);
        #1;
        p_in = 1'b0;
        lat  = 1;
        while (!rise_tick && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("rise_tick_latency", 64'(lat), 64'(SS + 1));
        // Timeout shows in the TO-th cycle counting rise_tick's as first.
        n = 0;
        while (!timeout && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t2_timeout_delay", 64'(n), 64'(TO - 1));
        check("t2_locked", 64'(locked), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check("t2_timeout_sticky", 64'(timeout), 64'(1));
        check("t2_no_meas", 64'(n_meas), 64'(n_exp));

        // Restart at 8/1: first rise clears timeout.
        pulse(8, 1, 1'b0);
        check("t3_timeout_cleared", 64'(timeout), 64'(0));
        check("t3_locked", 64'(locked), 64'(1));
        repeat (3) pulse(8, 1, 1'b0);

        // Fastest input: alternating 1/0.
        repeat (10) pulse(2, 1, 1'b0);

        // Period TO-1 still measures; period TO times out.
        pulse(19, 3, 1'b0);
        pulse(TO, 3, 1'b0);
        pulse(5, 2, 1'b0);
        pulse(6, 1, 1'b0);
        // Stuck high beyond the timeout.
        pulse(TO + 15, TO + 14, 1'b0);
        check("stuck_high_timeout", 64'(timeout), 64'(1));
        pulse(7, 2, 1'b0);
        check("t4_meas_count", 64'(n_meas), 64'(n_exp));

        for (int k = 0; k < 40; k++) begin
            int P;
            int W;
            if ($urandom_range(7, 0) == 0)
                P = int'($urandom_range(TO + 8, TO + 2));
            else
                P = int'($urandom_range(TO - 1, 2));
            W = int'($urandom_range(P - 1, 1));
            pulse(P, W, 1'b0);
            check("rand_timeout", 64'(timeout), 64'(P >= TO));
            check("rand_locked", 64'(locked), 64'(P < TO));
        end
        pulse(6, 2, 1'b0);
        check("rand_meas_count", 64'(n_meas), 64'(n_exp));

        // Reset in the middle of a period.
        repeat (2) pulse(10, 4, 1'b0);
        bookkeep(10, 4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            p_in = (i < 2);
            @(posedge clk);
            #1;
        end
        do_reset();
        repeat (3) pulse(7, 3, 1'b0);
        pulse(5, 2, 1'b0);
        check("t5_meas_count", 64'(n_meas), 64'(n_exp));

`ifdef PULSE_METER_MINMAX_EN
        pulse(TO + 10, 2, 1'b0);
        minmax_clr = 1'b1;
        @(posedge clk);
        #1;
        minmax_clr = 1'b0;
        m_min = ALL1;
        m_max = 0;
        check("mm_clr_min", 64'(min_period), 64'(ALL1));
        check("mm_clr_max", 64'(max_period), 64'(0));
        pulse(10, 3, 1'b0);
        pulse(6, 2, 1'b0);
        pulse(14, 5, 1'b0);
        pulse(9, 4, 1'b0);
        check("mm_min_6", 64'(min_period), 64'(6));
        check("mm_max_14", 64'(max_period), 64'(14));
        minmax_clr = 1'b1;
        @(posedge clk);
        #1;
        minmax_clr = 1'b0;
        m_min = ALL1;
        m_max = 0;
        check("mm_clr2_min", 64'(min_period), 64'(ALL1));
        check("mm_clr2_max", 64'(max_period), 64'(0));
        pulse(5, 2, 1'b0);
        check("mm_min_9", 64'(min_period), 64'(9));
        check("mm_max_9", 64'(max_period), 64'(9));
        // Clear coinciding with a result keeps that result.
        pulse(7, 3, 1'b1);
        check("mm_same_min", 64'(min_period), 64'(5));
        check("mm_same_max", 64'(max_period), 64'(5));
        pulse(4, 1, 1'b0);
        check("mm_after_max", 64'(max_period), 64'(7));
        check("mm_meas_count", 64'(n_meas), 64'(n_exp));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
